// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the calculator's datapath blocks.
package calc_pkg;
    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    // A divide by zero saturates the quotient by filling every bit with this value.
    localparam logic Q_SAT_BIT = 1'b1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (shift in a dividend bit, then trial-subtract).
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   rem_o,
    output logic          qbit_o
);
    logic [VW+1:0] sh;
    assign sh     = {rem_i, bit_i};
    assign qbit_o = sh >= {2'b00, divisor_i};
    assign rem_o  = (VW+1)'(qbit_o ? sh - {2'b00, divisor_i} : sh);
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider that produces one quotient bit per clock.
module seq_divider
    import calc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = $clog2(DW);
    div_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   rem_q, rem_d;
    logic          qbit_d;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          busy_q, done_q, dbz_q;
    div_step #(.VW(VW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit_d)
    );
    // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (divisor != '0) begin
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        rem_q   <= '0;
                        cnt_q   <= CW'(DW-1);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        quotient_q  <= {DW{Q_SAT_BIT}};
                        remainder_q <= '0;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[DW-2:0], qbit_d};
                    if (cnt_q == '0) begin
                        quotient_q  <= {dvd_q[DW-2:0], qbit_d};
                        remainder_q <= rem_d[VW-1:0];
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider that performs the inverse of the calculator's multiply path: it takes an 8-bit dividend, such as a 4x4 product, and a 4-bit divisor. It returns an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. It sits beside the combinational calculator datapath and is driven by a start/done handshake, so a control FSM can add a divide operation without lengthening the combinational path.

## Interface
Parameters:
- DW, 8, dividend and quotient width
- VW, 4, divisor and remainder width

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  DW  unsigned dividend; sampled with start
- divisor  input  VW  unsigned divisor; sampled with start
- busy  output  1  high while an operation is in progress (CALC)
- done  output  1  one-cycle completion pulse
- quotient  output  DW  result quotient
- remainder  output  VW  result remainder
- div_by_zero  output  1  set when the last operation had divisor == 0

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with start=1 and divisor!=0:
  - latch operands and clear the partial remainder (VW+1 bits)
  - load step counter = DW-1
  - go to CALC
- IDLE with start=1 and divisor==0:
  - go directly to DONE
  - quotient=all ones (8'hFF), remainder=0, div_by_zero=1
- CALC, one restoring step per cycle, MSB of the dividend first:
  - shift the next dividend bit into the partial remainder
  - trial-subtract the divisor
  - if non-negative, keep the difference and shift in quotient bit 1; else keep the shifted remainder and shift in 0
  - after the step with counter==0, write quotient/remainder to the outputs, clear div_by_zero, go to DONE
- DONE: done=1 for exactly this cycle; next state is IDLE unconditionally.
- start outside IDLE (CALC or DONE) is ignored; there is no queueing.
- Operand inputs may change freely after the accepting edge.
- quotient, remainder and div_by_zero hold their values until the next operation completes. They are not cleared when an operation starts.
- Arithmetic is fully unsigned; the trial subtraction uses VW+1 bits so there is no overflow.
- Invariant: quotient*divisor + remainder == dividend, with remainder < divisor.

## Timing
- Reset (rst_n low, asynchronous) forces state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0 and the internal partial remainder to 0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Normal divide, with start accepted at edge k:
  - busy=1 after edges k..k+DW-1
  - the final step occurs at edge k+DW; results are valid and done=1 after edge k+DW
  - busy=0 in the DONE cycle
  - IDLE after edge k+DW+1
- Latency is DW+1 cycles from start to done (9 at defaults).
- Divide by zero: done=1 after edge k (one cycle later); busy never asserts.
- Earliest next start is the cycle after done (back in IDLE), which gives a throughput of one operation per DW+2 cycles.

## Structure
- Shared package calc_pkg holds:
  - DW/VW default constants
  - the divider state enum (IDLE, CALC, DONE)
  - the quotient saturation value for divide-by-zero
- One sub-module, div_step: combinational shift/trial-subtract. Its inputs are the partial remainder, the incoming dividend bit and the divisor. Its outputs are the next partial remainder and the quotient bit.
- The top level holds the FSM, the counter and the registers.

## Test plan
- 143 / 11 -> after 9 cycles: done pulse, quotient=13, remainder=0, div_by_zero=0; busy high for exactly 8 cycles.
- 200 / 7 -> quotient=28, remainder=4. Then 255 / 1 -> quotient=255, remainder=0. Then 5 / 9 -> quotient=0, remainder=5. All use back-to-back starts issued the cycle after each done.
- 100 / 0 -> done one cycle after start, quotient=8'hFF, remainder=0, div_by_zero=1, busy never high. A following 12 / 4 -> quotient=3, remainder=0, div_by_zero=0.
- Start held high and operands changed during CALC -> the in-flight result is unaffected. The second start is taken only in IDLE, and exactly one done is produced per accepted start.
- rst_n pulsed low at cycle 4 of a 143 / 11 operation:
  - all outputs 0 immediately (asynchronously)
  - no done pulse
  - a subsequent 143 / 11 completes correctly
- Exhaustive sweep of all 256x15 nonzero operand pairs -> quotient*divisor+remainder==dividend and remainder<divisor for every pair.
